// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue/result bundle between the reservation station and the ALU pipeline
interface alu_pipe_if #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 4
);
  logic              rs_shot;
  logic [31:0]       alu_r1;
  logic [31:0]       alu_r2;
  logic [ROB_W-1:0]  alu_rob_id;
  logic [TYPE_W-1:0] alu_work_type;
  logic              alu_ready;
  logic [ROB_W-1:0]  alu_res_rob_id;
  logic [31:0]       alu_value;

  modport master (
    output rs_shot, alu_r1, alu_r2, alu_rob_id, alu_work_type,
    input  alu_ready, alu_res_rob_id, alu_value
  );

  modport slave (
    input  rs_shot, alu_r1, alu_r2, alu_rob_id, alu_work_type,
    output alu_ready, alu_res_rob_id, alu_value
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage integer ALU feeding the reservation-station broadcast
module alu_pipe #(
  parameter int ROB_W  = 4,
  parameter int TYPE_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  alu_pipe_if.slave   bus
);

  localparam logic [TYPE_W-1:0] OP_ADD  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] OP_SUB  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] OP_AND  = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] OP_OR   = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] OP_XOR  = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] OP_SLL  = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] OP_SRL  = TYPE_W'(6);
  localparam logic [TYPE_W-1:0] OP_SRA  = TYPE_W'(7);
  localparam logic [TYPE_W-1:0] OP_SLT  = TYPE_W'(8);
  localparam logic [TYPE_W-1:0] OP_SLTU = TYPE_W'(9);
  localparam logic [TYPE_W-1:0] OP_BEQ  = TYPE_W'(10);
  localparam logic [TYPE_W-1:0] OP_BNE  = TYPE_W'(11);
  localparam logic [TYPE_W-1:0] OP_BLT  = TYPE_W'(12);
  localparam logic [TYPE_W-1:0] OP_BGE  = TYPE_W'(13);
  localparam logic [TYPE_W-1:0] OP_BLTU = TYPE_W'(14);
  localparam logic [TYPE_W-1:0] OP_BGEU = TYPE_W'(15);

  logic              r_v1;
  logic [31:0]       r_r1;
  logic [31:0]       r_r2;
  logic [ROB_W-1:0]  r_tag1;
  logic [TYPE_W-1:0] r_type1;
  logic              r_v2;
  logic [ROB_W-1:0]  r_tag2;
  logic [31:0]       r_val2;

  logic [4:0]        w_shamt;
  logic              w_lt_s;
  logic              w_lt_u;
  logic              w_eq;
  logic [31:0]       w_value;

  assign w_shamt = r_r2[4:0];
  assign w_lt_s  = $signed(r_r1) < $signed(r_r2);
  assign w_lt_u  = r_r1 < r_r2;
  assign w_eq    = r_r1 == r_r2;

  // Result is computed from the S1 registers and captured into S2.
  always_comb begin
    w_value = '0;
    case (r_type1)
      OP_ADD:  w_value = r_r1 + r_r2;
      OP_SUB:  w_value = r_r1 - r_r2;
      OP_AND:  w_value = r_r1 & r_r2;
      OP_OR:   w_value = r_r1 | r_r2;
      OP_XOR:  w_value = r_r1 ^ r_r2;
      OP_SLL:  w_value = r_r1 << w_shamt;
      OP_SRL:  w_value = r_r1 >> w_shamt;
      OP_SRA:  w_value = $unsigned($signed(r_r1) >>> w_shamt);
      OP_SLT:  w_value = {31'd0, w_lt_s};
      OP_SLTU: w_value = {31'd0, w_lt_u};
      OP_BEQ:  w_value = {31'd0, w_eq};
      OP_BNE:  w_value = {31'd0, ~w_eq};
      OP_BLT:  w_value = {31'd0, w_lt_s};
      OP_BGE:  w_value = {31'd0, ~w_lt_s};
      OP_BLTU: w_value = {31'd0, w_lt_u};
      OP_BGEU: w_value = {31'd0, ~w_lt_u};
      default: w_value = '0;
    endcase
  end

  // A flush wins over the rdy freeze so a mispredict is never held off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_r1    <= '0;
      r_r2    <= '0;
      r_tag1  <= '0;
      r_type1 <= '0;
      r_v2    <= 1'b0;
      r_tag2  <= '0;
      r_val2  <= '0;
    end else if (clear) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else if (rdy) begin
      r_v1 <= bus.rs_shot;
      if (bus.rs_shot) begin
        r_r1    <= bus.alu_r1;
        r_r2    <= bus.alu_r2;
        r_tag1  <= bus.alu_rob_id;
        r_type1 <= bus.alu_work_type;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_tag2 <= r_tag1;
        r_val2 <= w_value;
      end
    end
  end

  assign bus.alu_ready      = r_v2;
  assign bus.alu_res_rob_id = r_tag2;
  assign bus.alu_value      = r_val2;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe
module tb_alu_pipe;

  logic clk;
  logic rst;
  logic rdy;
  logic clear;

  alu_pipe_if #(.ROB_W(4), .TYPE_W(4)) bus ();

  alu_pipe #(.ROB_W(4), .TYPE_W(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    bit          v;
    logic [3:0]  tag;
    logic [31:0] val;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bus.rs_shot       = 1'b1;
    bus.alu_work_type = op;
    bus.alu_r1        = a;
    bus.alu_r2        = b;
    bus.alu_rob_id    = tag;
  endtask

  task automatic idle();
    bus.rs_shot = 1'b0;
  endtask

  // Reference: shifts as multiply/divide by powers of two, signed compare by bias flip.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned p;
    bit lt_s;
    bit lt_u;
    logic [31:0] fill;
    p    = 64'd1 << (b & 32'd31);
    lt_s = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    lt_u = a < b;
    fill = a[31] ? ~32'(64'hFFFF_FFFF / p) : 32'd0;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 32'(64'(a) * p);
      4'd6:  return 32'(64'(a) / p);
      4'd7:  return 32'(64'(a) / p) | fill;
      4'd8:  return {31'd0, lt_s};
      4'd9:  return {31'd0, lt_u};
      4'd10: return {31'd0, a == b};
      4'd11: return {31'd0, a != b};
      4'd12: return {31'd0, lt_s};
      4'd13: return {31'd0, !lt_s};
      4'd14: return {31'd0, lt_u};
      default: return {31'd0, !lt_u};
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  vec_t vecs [16];
  res_t exp_q [$];
  res_t acc_q [$];

  initial begin
    res_t r;
    res_t e;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000};
    vecs[1]  = '{4'd1,  32'h0000_0000, 32'h0000_0001, 4'd1,  32'hFFFF_FFFF};
    vecs[2]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2,  32'hF000_F000};
    vecs[3]  = '{4'd3,  32'h1234_0000, 32'h0000_5678, 4'd4,  32'h1234_5678};
    vecs[4]  = '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 4'd5,  32'hF0F0_0F0F};
    vecs[5]  = '{4'd5,  32'h0000_0001, 32'h0000_003F, 4'd6,  32'h8000_0000};
    vecs[6]  = '{4'd6,  32'h8000_0000, 32'h0000_001F, 4'd7,  32'h0000_0001};
    vecs[7]  = '{4'd7,  32'h8000_0000, 32'h0000_0024, 4'd8,  32'hF800_0000};
    vecs[8]  = '{4'd8,  32'h7FFF_FFFF, 32'h8000_0000, 4'd9,  32'h0000_0000};
    vecs[9]  = '{4'd9,  32'h7FFF_FFFF, 32'h8000_0000, 4'd10, 32'h0000_0001};
    vecs[10] = '{4'd10, 32'h0000_0005, 32'h0000_0005, 4'd11, 32'h0000_0001};
    vecs[11] = '{4'd11, 32'h0000_0005, 32'h0000_0005, 4'd12, 32'h0000_0000};
    vecs[12] = '{4'd12, 32'h8000_0000, 32'h7FFF_FFFF, 4'd13, 32'h0000_0001};
    vecs[13] = '{4'd13, 32'hFFFF_FFFF, 32'h0000_0000, 4'd14, 32'h0000_0000};
    vecs[14] = '{4'd14, 32'h8000_0000, 32'h7FFF_FFFF, 4'd15, 32'h0000_0000};
    vecs[15] = '{4'd15, 32'h8000_0000, 32'h7FFF_FFFF, 4'd0,  32'h0000_0001};

    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    bus.rs_shot = 1'b0; bus.alu_r1 = '0; bus.alu_r2 = '0;
    bus.alu_rob_id = '0; bus.alu_work_type = '0;
    #12;
    check("reset_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("reset_tag", {28'd0, bus.alu_res_rob_id}, 32'd0);
    check("reset_value", bus.alu_value, 32'd0);
    rst = 1'b1;
    tick();

    // Scenario 1: latency and single-cycle visibility
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3);
    tick(); idle();
    check("t1_ready_e0", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    check("t1_ready_e1", {31'd0, bus.alu_ready}, 32'd1);
    check("t1_tag", {28'd0, bus.alu_res_rob_id}, 32'd3);
    check("t1_value", bus.alu_value, 32'd0);
    tick();
    check("t1_ready_e2", {31'd0, bus.alu_ready}, 32'd0);

    // Opcode table, one op at a time
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      tick(); idle();
      tick();
      check($sformatf("vec%0d_ready", i), {31'd0, bus.alu_ready}, 32'd1);
      check($sformatf("vec%0d_tag", i), {28'd0, bus.alu_res_rob_id}, {28'd0, vecs[i].tag});
      check($sformatf("vec%0d_value", i), bus.alu_value, vecs[i].exp);
      tick();
      check($sformatf("vec%0d_drop", i), {31'd0, bus.alu_ready}, 32'd0);
    end

    // Scenario 2: back-to-back issue
    issue(4'd7, 32'h8000_0000, 32'h0000_0024, 4'd1);
    tick();
    issue(4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 4'd2);
    tick(); idle();
    check("t2_ready_a", {31'd0, bus.alu_ready}, 32'd1);
    check("t2_value_a", bus.alu_value, 32'hF800_0000);
    tick();
    check("t2_ready_b", {31'd0, bus.alu_ready}, 32'd1);
    check("t2_value_b", bus.alu_value, 32'd1);
    check("t2_tag_b", {28'd0, bus.alu_res_rob_id}, 32'd2);
    tick();
    check("t2_ready_end", {31'd0, bus.alu_ready}, 32'd0);

    // Scenario 3: freeze after issue
    issue(4'd13, 32'hFFFF_FFFF, 32'd0, 4'd9);
    tick(); idle(); rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_frozen%0d", i), {31'd0, bus.alu_ready}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("t3_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("t3_value", bus.alu_value, 32'd0);
    check("t3_tag", {28'd0, bus.alu_res_rob_id}, 32'd9);
    // A valid result must hold while frozen
    rdy = 1'b0;
    tick();
    check("t3_hold", {31'd0, bus.alu_ready}, 32'd1);
    rdy = 1'b1;
    tick();
    check("t3_after", {31'd0, bus.alu_ready}, 32'd0);

    // Scenario 4: flush with two ops in flight plus a new shot
    issue(4'd0, 32'd10, 32'd20, 4'd1);
    tick();
    issue(4'd0, 32'd30, 32'd40, 4'd2);
    tick();
    check("t4_pre_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("t4_pre_value", bus.alu_value, 32'd30);
    issue(4'd0, 32'd50, 32'd60, 4'd3);
    clear = 1'b1;
    tick(); clear = 1'b0; idle();
    check("t4_flush1", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    check("t4_flush2", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    check("t4_flush3", {31'd0, bus.alu_ready}, 32'd0);

    // Scenario 5: asynchronous reset with a valid result showing
    issue(4'd1, 32'd100, 32'd1, 4'd7);
    tick(); idle();
    tick();
    check("t5_pre_ready", {31'd0, bus.alu_ready}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_rst_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("t5_rst_tag", {28'd0, bus.alu_res_rob_id}, 32'd0);
    check("t5_rst_value", bus.alu_value, 32'd0);
    #1 rst = 1'b1;
    tick();
    issue(4'd0, 32'd2, 32'd3, 4'd5);
    tick(); idle();
    check("t5_lat1", {31'd0, bus.alu_ready}, 32'd0);
    tick();
    check("t5_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("t5_value", bus.alu_value, 32'd5);
    tick();

    // Scenario 6: full-rate sweep of every opcode
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 1000; k++) begin
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        a   = rand_operand();
        b   = rand_operand();
        tag = 4'($urandom_range(0, 15));
        if (k == 0) begin a = 32'h7FFF_FFFF; b = 32'h8000_0000; end
        if (k == 1) begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
        issue(4'(op), a, b, tag);
        r.v = 1'b1; r.tag = tag; r.val = ref_alu(4'(op), a, b);
        exp_q.push_back(r);
        tick();
        if (exp_q.size() >= 2) begin
          e = exp_q.pop_front();
          check("sweep_ready", {31'd0, bus.alu_ready}, 32'd1);
          check("sweep_tag", {28'd0, bus.alu_res_rob_id}, {28'd0, e.tag});
          check($sformatf("sweep_op%0d", op), bus.alu_value, e.val);
        end
      end
    end
    idle();
    tick();
    e = exp_q.pop_front();
    check("sweep_last_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("sweep_last_value", bus.alu_value, e.val);
    tick();
    tick();

    // Random issue with random freezes: result shows one accepted edge after its issue edge
    r.v = 1'b0; r.tag = '0; r.val = '0;
    acc_q.push_back(r);
    for (int c = 0; c < 1500; c++) begin
      logic take;
      rdy  = ($urandom_range(0, 3) != 0);
      take = ($urandom_range(0, 1) == 1);
      r.v = take; r.tag = 4'($urandom_range(0, 15));
      issue(4'($urandom_range(0, 15)), rand_operand(), rand_operand(), r.tag);
      bus.rs_shot = take;
      r.val = ref_alu(bus.alu_work_type, bus.alu_r1, bus.alu_r2);
      if (rdy) acc_q.push_back(r);
      if (acc_q.size() > 2) void'(acc_q.pop_front());
      tick();
      if (acc_q.size() >= 2) e = acc_q[0];
      else e.v = 1'b0;
      check("rand_ready", {31'd0, bus.alu_ready}, {31'd0, e.v});
      if (e.v && bus.alu_ready) begin
        check("rand_tag", {28'd0, bus.alu_res_rob_id}, {28'd0, e.tag});
        check("rand_value", bus.alu_value, e.val);
      end
    end
    idle();
    rdy = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
